// File: rtl/time_counter.sv
// time_counter: timekeeping core of the digital clock.
//
// Divides clk down to a 1 Hz tick and keeps hours/minutes/seconds as plain binary.
// A two-button state machine (RUN -> SET_HOUR -> SET_MIN -> RUN) sets the time.
// All outputs are registered and never exceed 23/59/59.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   mode_btn  raw mode button level (asynchronous, active-high)
//   inc_btn   raw increment button level (asynchronous, active-high)
//   hours     binary 0..23
//   minutes   binary 0..59
//   seconds   binary 0..59
//   tick_1hz  one-cycle pulse on each prescaler wrap in RUN
//   set_hour  high while in SET_HOUR
//   set_min   high while in SET_MIN
module time_counter #(
    parameter int unsigned DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [7:0] hours,
    output logic [7:0] minutes,
    output logic [7:0] seconds,
    output logic       tick_1hz,
    output logic       set_hour,
    output logic       set_min
);

    localparam int unsigned PW = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    typedef enum logic [1:0] {StRun, StSetHour, StSetMin} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    hours_q, hours_d;
    logic [7:0]    minutes_q, minutes_d;
    logic [7:0]    seconds_q, seconds_d;
    logic          tick_q, tick_d;
    logic          set_hour_q, set_min_q;

    logic [1:0] mode_sync_q, inc_sync_q;
    logic       mode_prev_q, inc_prev_q;
    logic       mode_ev, inc_ev, wrap;

    // One event per press: rising edge of the synchronised level.
    assign mode_ev = mode_sync_q[1] & ~mode_prev_q;
    // Mode wins over a simultaneous inc event.
    assign inc_ev  = inc_sync_q[1] & ~inc_prev_q & ~mode_ev;
    assign wrap    = (presc_q == PRESC_MAX);

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        unique case (state_q)
            StRun: begin
                presc_d = wrap ? '0 : presc_q + 1'b1;
                if (wrap) begin
                    if (seconds_q == 8'd59) begin
                        seconds_d = 8'd0;
                        if (minutes_q == 8'd59) begin
                            minutes_d = 8'd0;
                            hours_d   = (hours_q == 8'd23) ? 8'd0 : hours_q + 8'd1;
                        end else begin
                            minutes_d = minutes_q + 8'd1;
                        end
                    end else begin
                        seconds_d = seconds_q + 8'd1;
                    end
                end
                if (mode_ev) begin
                    state_d = StSetHour;
                    presc_d = '0;
                end
            end
            StSetHour: begin
                presc_d = '0;
                if (mode_ev) begin
                    state_d = StSetMin;
                end else if (inc_ev) begin
                    hours_d = (hours_q == 8'd23) ? 8'd0 : hours_q + 8'd1;
                end
            end
            StSetMin: begin
                presc_d = '0;
                if (mode_ev) begin
                    // Restart the second cleanly so the first tick is a full DIV away.
                    state_d   = StRun;
                    seconds_d = 8'd0;
                end else if (inc_ev) begin
                    minutes_d = (minutes_q == 8'd59) ? 8'd0 : minutes_q + 8'd1;
                end
            end
            default: begin
                state_d = StRun;
                presc_d = '0;
            end
        endcase
        // Registered tick: high during the cycle in which the prescaler sits at DIV-1.
        tick_d = (state_d == StRun) && (presc_d == PRESC_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            presc_q     <= '0;
            hours_q     <= 8'd0;
            minutes_q   <= 8'd0;
            seconds_q   <= 8'd0;
            tick_q      <= 1'b0;
            set_hour_q  <= 1'b0;
            set_min_q   <= 1'b0;
            mode_sync_q <= 2'b00;
            inc_sync_q  <= 2'b00;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            hours_q     <= hours_d;
            minutes_q   <= minutes_d;
            seconds_q   <= seconds_d;
            tick_q      <= tick_d;
            set_hour_q  <= (state_d == StSetHour);
            set_min_q   <= (state_d == StSetMin);
            mode_sync_q <= {mode_sync_q[0], mode_btn};
            inc_sync_q  <= {inc_sync_q[0], inc_btn};
            mode_prev_q <= mode_sync_q[1];
            inc_prev_q  <= inc_sync_q[1];
        end
    end

    assign hours    = hours_q;
    assign minutes  = minutes_q;
    assign seconds  = seconds_q;
    assign tick_1hz = tick_q;
    assign set_hour = set_hour_q;
    assign set_min  = set_min_q;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter with DIV = 4.
module tb_time_counter;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [7:0] hours, minutes, seconds;
    logic       tick_1hz, set_hour, set_min;

    int errors = 0;
    int checks = 0;

    time_counter #(.DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode_btn (mode_btn),
        .inc_btn  (inc_btn),
        .hours    (hours),
        .minutes  (minutes),
        .seconds  (seconds),
        .tick_1hz (tick_1hz),
        .set_hour (set_hour),
        .set_min  (set_min)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        rst_n    = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    // Hold for 3 edges (event applied on the 3rd), then release for 3 edges.
    task automatic press(input logic m, input logic i);
        mode_btn = m;
        inc_btn  = i;
        step(3);
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        step(3);
    endtask

    task automatic test_reset();
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        rst_n    = 1'b0;
        step(2);
        checks++; if ({hours, minutes, seconds} !== 24'd0) begin errors++; $display("FAIL reset_time: got %0d:%0d:%0d want 0:0:0", hours, minutes, seconds); end
        checks++; if ({tick_1hz, set_hour, set_min} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {tick_1hz, set_hour, set_min}); end
        rst_n = 1'b1;
        step(2);
        checks++; if (tick_1hz !== 1'b0) begin errors++; $display("FAIL tick_early: got %b want 0", tick_1hz); end
        step(1);
        checks++; if (tick_1hz !== 1'b1 || seconds !== 8'd0) begin errors++; $display("FAIL tick_first: got tick=%b sec=%0d want tick=1 sec=0", tick_1hz, seconds); end
        step(1);
        checks++; if (tick_1hz !== 1'b0 || seconds !== 8'd1) begin errors++; $display("FAIL sec_1: got tick=%b sec=%0d want tick=0 sec=1", tick_1hz, seconds); end
        step(3);
        checks++; if (tick_1hz !== 1'b1) begin errors++; $display("FAIL tick_second: got %b want 1", tick_1hz); end
        step(1);
        checks++; if (seconds !== 8'd2 || tick_1hz !== 1'b0) begin errors++; $display("FAIL sec_2: got tick=%b sec=%0d want tick=0 sec=2", tick_1hz, seconds); end
    endtask

    task automatic test_carry();
        do_reset();
        step(236);
        checks++; if ({hours, minutes, seconds} !== {8'd0, 8'd0, 8'd59}) begin errors++; $display("FAIL t_0_0_59: got %0d:%0d:%0d want 0:0:59", hours, minutes, seconds); end
        step(4);
        checks++; if ({hours, minutes, seconds} !== {8'd0, 8'd1, 8'd0}) begin errors++; $display("FAIL t_0_1_0: got %0d:%0d:%0d want 0:1:0", hours, minutes, seconds); end
        step(14156);
        checks++; if ({hours, minutes, seconds} !== {8'd0, 8'd59, 8'd59}) begin errors++; $display("FAIL t_0_59_59: got %0d:%0d:%0d want 0:59:59", hours, minutes, seconds); end
        step(4);
        checks++; if ({hours, minutes, seconds} !== {8'd1, 8'd0, 8'd0}) begin errors++; $display("FAIL t_1_0_0: got %0d:%0d:%0d want 1:0:0", hours, minutes, seconds); end
    endtask

    task automatic test_set_sequence();
        do_reset();
        mode_btn = 1'b1;
        step(2);
        checks++; if (set_hour !== 1'b0) begin errors++; $display("FAIL set_hour_early: got %b want 0", set_hour); end
        step(1);
        checks++; if (set_hour !== 1'b1) begin errors++; $display("FAIL set_hour_3edges: got %b want 1", set_hour); end
        mode_btn = 1'b0;
        step(3);
        repeat (25) press(1'b0, 1'b1);
        checks++; if (hours !== 8'd1 || minutes !== 8'd0) begin errors++; $display("FAIL hour_wrap: got h=%0d m=%0d want h=1 m=0", hours, minutes); end
        press(1'b1, 1'b0);
        checks++; if (set_min !== 1'b1 || set_hour !== 1'b0) begin errors++; $display("FAIL to_set_min: got hr=%b mn=%b want hr=0 mn=1", set_hour, set_min); end
        repeat (61) press(1'b0, 1'b1);
        checks++; if (minutes !== 8'd1 || hours !== 8'd1) begin errors++; $display("FAIL min_wrap: got h=%0d m=%0d want h=1 m=1", hours, minutes); end
        mode_btn = 1'b1;
        step(3);
        checks++; if (set_min !== 1'b0 || seconds !== 8'd0 || tick_1hz !== 1'b0) begin errors++; $display("FAIL exit_run: got mn=%b sec=%0d tick=%b want 0 0 0", set_min, seconds, tick_1hz); end
        mode_btn = 1'b0;
        step(2);
        checks++; if (tick_1hz !== 1'b0) begin errors++; $display("FAIL exit_tick_early: got %b want 0", tick_1hz); end
        step(1);
        checks++; if (tick_1hz !== 1'b1 || seconds !== 8'd0) begin errors++; $display("FAIL exit_tick: got tick=%b sec=%0d want 1 0", tick_1hz, seconds); end
        step(1);
        checks++; if (seconds !== 8'd1 || {hours, minutes} !== {8'd1, 8'd1}) begin errors++; $display("FAIL exit_sec1: got %0d:%0d:%0d want 1:1:1", hours, minutes, seconds); end
    endtask

    task automatic test_rollover();
        do_reset();
        press(1'b1, 1'b0);
        repeat (23) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (59) press(1'b0, 1'b1);
        checks++; if ({hours, minutes, set_min} !== {8'd23, 8'd59, 1'b1}) begin errors++; $display("FAIL preset_23_59: got h=%0d m=%0d mn=%b want 23 59 1", hours, minutes, set_min); end
        press(1'b1, 1'b0);
        step(233);
        checks++; if ({hours, minutes, seconds} !== {8'd23, 8'd59, 8'd59}) begin errors++; $display("FAIL t_23_59_59: got %0d:%0d:%0d want 23:59:59", hours, minutes, seconds); end
        step(4);
        checks++; if ({hours, minutes, seconds} !== 24'd0) begin errors++; $display("FAIL t_midnight: got %0d:%0d:%0d want 0:0:0", hours, minutes, seconds); end
    endtask

    task automatic test_held_button();
        do_reset();
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        inc_btn = 1'b1;
        step(100);
        inc_btn = 1'b0;
        step(3);
        checks++; if (minutes !== 8'd1 || set_min !== 1'b1) begin errors++; $display("FAIL held_inc: got m=%0d mn=%b want m=1 mn=1", minutes, set_min); end
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        // 15 edges in RUN since the exit edge: three full seconds elapsed.
        checks++; if ({hours, minutes, seconds} !== {8'd0, 8'd1, 8'd3}) begin errors++; $display("FAIL run_inc_ignored: got %0d:%0d:%0d want 0:1:3", hours, minutes, seconds); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        checks++; if ({set_hour, set_min} !== 2'b01 || hours !== 8'd0) begin errors++; $display("FAIL simul: got hr=%b mn=%b h=%0d want 0 1 0", set_hour, set_min, hours); end
    endtask

    task automatic test_async_reset();
        do_reset();
        press(1'b1, 1'b0);
        repeat (12) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (34) press(1'b0, 1'b1);
        checks++; if ({hours, minutes, set_min} !== {8'd12, 8'd34, 1'b1}) begin errors++; $display("FAIL preset_12_34: got h=%0d m=%0d mn=%b want 12 34 1", hours, minutes, set_min); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({hours, minutes, seconds} !== 24'd0) begin errors++; $display("FAIL async_time: got %0d:%0d:%0d want 0:0:0", hours, minutes, seconds); end
        checks++; if ({tick_1hz, set_hour, set_min} !== 3'b000) begin errors++; $display("FAIL async_flags: got %b want 000", {tick_1hz, set_hour, set_min}); end
        step(1);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_carry();
        test_set_sequence();
        test_rollover();
        test_held_button();
        test_simultaneous();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
